// File: rtl/ht24x0_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ht24x0_kbd_pkg
//  Description : Shared types and defaults for the ht24x0 keypad/switch scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package ht24x0_kbd_pkg;

    localparam int c_KEY_W         = 2;
    localparam int c_NUM_KEYS      = 4;
    localparam int c_NUM_SW        = 4;
    localparam int c_TICK_DIV_DEF  = 10000;
    localparam int c_DEB_CNT_DEF   = 8;
    localparam int c_REPEAT_DEF    = 500;

    typedef enum logic [0:0] {
        COL0 = 1'b0,
        COL1 = 1'b1
    } scan_state_t;

    // Column drive pattern: the driven column is the one pulled low.
    function automatic logic [1:0] col_drive(input scan_state_t s);
        return (s == COL0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [c_KEY_W-1:0] lowest_key(input logic [c_NUM_KEYS-1:0] mask);
        logic [c_KEY_W-1:0] code;
        code = '0;
        for (int i = c_NUM_KEYS - 1; i >= 0; i--) begin
            if (mask[i]) code = c_KEY_W'(i);
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ht24x0_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : ht24x0_debounce
//  Description : Single-bit 2-flop synchroniser followed by a sample-enabled
//                debounce counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ht24x0_debounce #(
    parameter int DEB_CNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    input  logic i_sample_en,
    output logic o_stable
);

    localparam logic [3:0] c_CNT_LAST = 4'(DEB_CNT - 1);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            o_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            if (i_sample_en) begin
                // Any sample agreeing with the stable state restarts the run.
                if (r_sync[1] == o_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    o_stable <= r_sync[1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ht24x0_key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : ht24x0_key_scan
//  Description : 2x2 keypad scanner and switch debouncer feeding a single-entry
//                key-event register. Optional macro KEY_REPEAT_EN adds auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module ht24x0_key_scan
    import ht24x0_kbd_pkg::*;
#(
    parameter int TICK_DIV     = c_TICK_DIV_DEF,
    parameter int DEB_CNT      = c_DEB_CNT_DEF,
    parameter int REPEAT_TICKS = c_REPEAT_DEF
) (
    input  logic                  CLK_10M,
    input  logic                  RST,
    input  logic [1:0]            KBIN,
    input  logic [c_NUM_SW-1:0]   SW_PIO,
    input  logic                  KEY_ACK,
    output logic [1:0]            KBOUT,
    output logic [c_NUM_SW-1:0]   SW_STABLE,
    output logic [c_KEY_W-1:0]    KEY_CODE,
    output logic                  KEY_VALID,
    output logic                  KEY_OVF,
    output logic                  KEY_IRQ
);

    localparam logic [15:0] c_TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0]             r_tick_cnt;
    logic                    w_tick;
    scan_state_t             r_state;
    logic [1:0]              w_col_en;
    logic [c_NUM_KEYS-1:0]   w_key_stable;
    logic [c_NUM_KEYS-1:0]   r_key_stable_d;
    logic [c_NUM_KEYS-1:0]   w_key_rise;
    logic [c_NUM_KEYS-1:0]   w_key_evt;
    logic [c_NUM_KEYS-1:0]   r_pending;
    logic [c_NUM_KEYS-1:0]   w_issue_oh;
    logic                    w_issue;
    logic [c_KEY_W-1:0]      w_issue_code;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge CLK_10M) begin
        if (RST || w_tick) r_tick_cnt <= '0;
        else               r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    always_ff @(posedge CLK_10M) begin
        if (RST) begin
            r_state <= COL0;
            KBOUT   <= col_drive(COL0);
        end else if (w_tick) begin
            r_state <= (r_state == COL0) ? COL1 : COL0;
            KBOUT   <= col_drive((r_state == COL0) ? COL1 : COL0);
        end
    end

    // Rows are sampled on the tick that ends a column's drive window.
    assign w_col_en[0] = w_tick && (r_state == COL0);
    assign w_col_en[1] = w_tick && (r_state == COL1);

    for (genvar i = 0; i < c_NUM_SW; i++) begin : g_sw
        ht24x0_debounce #(.DEB_CNT(DEB_CNT)) u_sw_deb (
            .clk         (CLK_10M),
            .rst         (RST),
            .i_din       (SW_PIO[i]),
            .i_sample_en (w_tick),
            .o_stable    (SW_STABLE[i])
        );
    end

    for (genvar k = 0; k < c_NUM_KEYS; k++) begin : g_key
        localparam int c_ROW = k % 2;
        localparam int c_COL = k / 2;
        ht24x0_debounce #(.DEB_CNT(DEB_CNT)) u_key_deb (
            .clk         (CLK_10M),
            .rst         (RST),
            .i_din       (~KBIN[c_ROW]),
            .i_sample_en (w_col_en[c_COL]),
            .o_stable    (w_key_stable[k])
        );
    end

    assign w_key_rise = w_key_stable & ~r_key_stable_d;

`ifdef KEY_REPEAT_EN
    localparam int c_HOLD_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(REPEAT_TICKS - 1);

    logic [c_NUM_KEYS-1:0] w_repeat;

    for (genvar k = 0; k < c_NUM_KEYS; k++) begin : g_hold
        logic [c_HOLD_W-1:0] r_hold;
        always_ff @(posedge CLK_10M) begin
            if (RST || !w_key_stable[k]) begin
                r_hold <= '0;
            end else if (w_tick) begin
                r_hold <= (r_hold == c_HOLD_LAST) ? '0 : r_hold + c_HOLD_W'(1);
            end
        end
        assign w_repeat[k] = w_tick && w_key_stable[k] && (r_hold == c_HOLD_LAST);
    end

    assign w_key_evt = w_key_rise | w_repeat;
`else
    assign w_key_evt = w_key_rise;
`endif

    // Lowest pending key wins; isolate it with the two's-complement trick.
    assign w_issue_oh   = r_pending & (~r_pending + 4'd1);
    assign w_issue      = |r_pending;
    assign w_issue_code = lowest_key(r_pending);

    always_ff @(posedge CLK_10M) begin
        if (RST) begin
            r_key_stable_d <= '0;
            r_pending      <= '0;
            KEY_CODE       <= '0;
            KEY_VALID      <= 1'b0;
            KEY_OVF        <= 1'b0;
            KEY_IRQ        <= 1'b0;
        end else begin
            r_key_stable_d <= w_key_stable;
            r_pending      <= (r_pending & ~w_issue_oh) | w_key_evt;
            KEY_IRQ        <= 1'b0;
            if (w_issue) begin
                if (!KEY_VALID || KEY_ACK) begin
                    KEY_CODE  <= w_issue_code;
                    KEY_VALID <= 1'b1;
                    KEY_IRQ   <= !KEY_VALID;
                    if (KEY_ACK) KEY_OVF <= 1'b0;
                end else begin
                    KEY_OVF <= 1'b1;
                end
            end else if (KEY_ACK) begin
                KEY_VALID <= 1'b0;
                KEY_OVF   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
